// File: rtl/frame_config_writer.sv
// Column configuration writer: parses a header, then for each data word drives FrameData and
// pulses one FrameStrobe line with a setup cycle before and a hold cycle after the strobe.
module frame_config_writer #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned StrobeWidth     = 1,
    parameter logic [15:0] SyncWord        = 16'hFAB0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned CntW = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;
    localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e                     state_q, state_d;
    logic [7:0]                 index_q, index_d;
    logic [7:0]                 remaining_q, remaining_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       err_q, err_d;

    logic       accepting;
    logic       xfer;
    logic [7:0] hdr_n;
    logic [7:0] hdr_i;
    logic [8:0] hdr_end;
    logic       hdr_ok;

    assign accepting = (state_q == StIdle) || (state_q == StWaitData);
    assign xfer      = s_valid & accepting;

    assign hdr_n   = s_data[15:8];
    assign hdr_i   = s_data[7:0];
    // 9-bit sum so a large start index cannot wrap back into range
    assign hdr_end = {1'b0, hdr_i} + {1'b0, hdr_n};
    assign hdr_ok  = (s_data[31:16] == SyncWord) && (hdr_n != 8'd0) &&
                     (hdr_end <= 9'(MaxFramesPerCol));

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        remaining_d  = remaining_q;
        cnt_d        = cnt_q;
        frame_data_d = frame_data_q;
        strobe_d     = '0;
        err_d        = 1'b0;

        case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        index_d     = hdr_i;
                        remaining_d = hdr_n;
                        state_d     = StWaitData;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWaitData: begin
                if (xfer) begin
                    frame_data_d = s_data[FrameBitsPerRow-1:0];
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                cnt_d    = CntW'(StrobeWidth - 1);
                strobe_d = StrobeOne << index_q;
                state_d  = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d    = cnt_q - CntW'(1);
                    strobe_d = StrobeOne << index_q;
                end
            end
            StHold: begin
                index_d     = index_q + 8'd1;
                remaining_d = remaining_q - 8'd1;
                state_d     = (remaining_q == 8'd1) ? StIdle : StWaitData;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            index_q      <= '0;
            remaining_q  <= '0;
            cnt_q        <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            remaining_q  <= remaining_d;
            cnt_q        <= cnt_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
        end
    end

    // Ready is decoded from the state register; RESET forces it low immediately
    assign s_ready     = accepting & ~RESET;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = (state_q != StIdle);
    assign err         = err_q;

endmodule

// File: doc/frame_config_writer.md
# frame_config_writer

Configuration-side writer for the fabric's frame-based configuration memory. Accepts a 32-bit word stream from the bitstream loader over a valid/ready handshake. For each data word it drives the column's `FrameData` bus and pulses exactly one `FrameStrobe` line, with setup and hold margins sized for the level-sensitive latches in each tile's config memory. One instance serves one column; its outputs fan out to every tile's ConfigMem in that column.

## Interface
- `MaxFramesPerCol`, 20, number of strobe lines; must be ≤ 255.
- `FrameBitsPerRow`, 32, FrameData width; must be ≤ 32. Data words use bits [FrameBitsPerRow-1:0].
- `StrobeWidth`, 1, cycles a strobe is held high; must be ≥ 1.
- `SyncWord`, 16'hFAB0, required header bits [31:16].
- `CLK`, in, 1, clock.
- `RESET`, in, 1, synchronous, active-high reset.
- `s_data`, in, 32, header or frame data word.
- `s_valid`, in, 1, `s_data` valid.
- `s_ready`, out, 1, writer can accept a word.
- `FrameData`, out, FrameBitsPerRow, data bus to the column's config latches.
- `FrameStrobe`, out, MaxFramesPerCol, one-hot latch enable (or all zero).
- `busy`, out, 1, high whenever state ≠ IDLE.
- `err`, out, 1, single-cycle pulse when a header is rejected.

## Operation
- Transfer occurs on any cycle with `s_valid & s_ready`.
- Header format: [31:16] = SyncWord, [15:8] = count N, [7:0] = start index I.
- Header is accepted only if the sync matches, N ≥ 1, and I+N ≤ MaxFramesPerCol. The range check uses 9-bit arithmetic (no wrap).
  - On accept: load index = I, remaining = N, go to WAIT_DATA.
  - On reject: stay in IDLE, pulse `err` in the next cycle, drive no strobe.
- States: IDLE → WAIT_DATA → SETUP → STROBE → HOLD → (WAIT_DATA if remaining > 0, else IDLE).
  - IDLE: `s_ready` = 1; the next word is treated as a header.
  - WAIT_DATA: `s_ready` = 1. On transfer, register `s_data[FrameBitsPerRow-1:0]` into `FrameData` and go to SETUP.
  - SETUP: 1 cycle, strobe low, `FrameData` stable.
  - STROBE: `FrameStrobe[index]` = 1 for StrobeWidth cycles, tracked by a down-counter.
  - HOLD: 1 cycle, strobe low, `FrameData` unchanged. Then index += 1 and remaining -= 1.
- `s_ready` is 0 in SETUP, STROBE and HOLD.
- `FrameData` changes only on a data-word transfer. It is never cleared except by reset.
- At most one `FrameStrobe` bit is ever high, and only in STROBE.
- A stall on `s_valid` in WAIT_DATA holds the state indefinitely, with strobes low and `FrameData` held.
- Reset values: `FrameData` = 0, `FrameStrobe` = 0, `s_ready` = 0 while RESET is high, `busy` = 0, `err` = 0, state = IDLE.
- Reset mid-operation (any state): all outputs return to reset values at the next edge. The partial frame is abandoned, and the next word after reset is parsed as a header.

## Timing
- All outputs are registered; there are no combinational paths from `s_data` or `s_valid` to any output.
- Data word transferred in cycle t:
  - `FrameData` valid from t+1 (SETUP).
  - `FrameStrobe` high for cycles t+2 … t+1+StrobeWidth.
  - Strobe low at t+2+StrobeWidth (HOLD).
  - `s_ready` = 1 again at t+3+StrobeWidth.
- Minimum frame period: StrobeWidth+3 cycles.
- Header rejected in cycle t: `err` = 1 in cycle t+1 only; `s_ready` stays 1.
- Header accepted in cycle t: `busy` = 1 from t+1.
- `busy` falls in the cycle after the last HOLD.

## Test plan
- Reset: hold RESET 3 cycles with `s_valid` = 1 → all outputs 0 throughout; `s_ready` = 1 in the first cycle after release.
- Single frame: header 32'hFAB0_0100, then data 32'hDEADBEEF accepted at t → `FrameData` = 32'hDEADBEEF from t+1; `FrameStrobe` = 20'h00001 at t+2 only; `s_ready` = 1 and `busy` = 0 at t+4.
- Burst at top of column: header 32'hFAB0_0212, data 32'h11111111 then 32'h22222222 → strobes 20'h40000 then 20'h80000 with the matching `FrameData`; no other strobe bit ever high.
- Rejects: headers 32'h1234_0100, 32'hFAB0_0313 (I+N = 22 > 20) and 32'hFAB0_0005 (N = 0) → each gives a one-cycle `err`, no strobe, state stays IDLE; a following valid header works normally.
- Stall: header 32'hFAB0_0200, first data word, then `s_valid` low for 10 cycles → state stays WAIT_DATA, `FrameStrobe` = 0, `FrameData` held; second word then strobes bit 1.
- Reset in STROBE with StrobeWidth = 4: assert RESET in the 2nd strobe cycle → `FrameStrobe` = 0 and state = IDLE from the next cycle; header 32'hFAB0_0103 plus a data word then strobes bit 3.
